// File: rtl/rv32i_imem_fetch.sv
// Single-line instruction buffer between the RV32I datapath and a request/grant
// instruction memory. A miss refills the whole line in order; hits are combinational.
module rv32i_imem_fetch #(
    parameter int          LINE_WORDS = 4,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic [31:0] cpu_add_i,
    output logic [31:0] cpu_data_o,
    output logic        cpu_valid_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_add_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        err_o
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                       state, state_nxt;
    logic                         line_valid;
    logic [TAG_W-1:0]             tag;
    logic [LINE_WORDS-1:0][31:0]  words;
    logic [CNT_W-1:0]             issue_cnt, recv_cnt;
    logic                         err_q;

    logic [TAG_W-1:0] cpu_tag;
    logic [IDX_W-1:0] cpu_idx;
    logic             unused_byte_bits;
    logic             hit, rsp_take, gnt_take, refill_err, refill_done;

    assign cpu_tag          = cpu_add_i[31:IDX_W+2];
    assign cpu_idx          = cpu_add_i[IDX_W+1:2];
    assign unused_byte_bits = ^cpu_add_i[1:0];

    assign hit         = line_valid && (tag == cpu_tag) && (state == IDLE) && !flush_i;
    assign cpu_valid_o = hit;
    assign cpu_data_o  = hit ? words[cpu_idx] : NOP_INSTR;

    assign mem_req_o = (state == REFILL) && (issue_cnt < FULL);
    assign mem_add_o = mem_req_o ? {tag, issue_cnt[IDX_W-1:0], 2'b00} : 32'h0;
    assign gnt_take  = mem_req_o && mem_gnt_i;

    // A response only counts while one of our requests is still unanswered;
    // this also drops stray beats that arrive after a reset abandoned a refill.
    assign rsp_take    = mem_rvalid_i && (state != IDLE) && (recv_cnt < issue_cnt);
    assign refill_err  = (state == REFILL) && rsp_take && mem_err_i;
    assign refill_done = (state == REFILL) && rsp_take && !mem_err_i && !flush_i
                         && (recv_cnt == LAST);
    assign err_o       = err_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!flush_i && !hit) state_nxt = REFILL;
            REFILL:  if (refill_err || flush_i) state_nxt = DRAIN;
                     else if (refill_done)      state_nxt = IDLE;
            DRAIN:   if (recv_cnt == issue_cnt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state      <= IDLE;
            line_valid <= 1'b0;
            tag        <= '0;
            words      <= '0;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= refill_err;
            if (state == IDLE) begin
                if (flush_i) begin
                    line_valid <= 1'b0;
                end else if (!hit) begin
                    line_valid <= 1'b0;
                    tag        <= cpu_tag;
                    issue_cnt  <= '0;
                    recv_cnt   <= '0;
                end
            end else begin
                if (gnt_take) issue_cnt <= issue_cnt + 1'b1;
                if (rsp_take) recv_cnt  <= recv_cnt + 1'b1;
            end
            if ((state == REFILL) && rsp_take && !mem_err_i)
                words[recv_cnt[IDX_W-1:0]] <= mem_rdata_i;
            if (refill_done) line_valid <= 1'b1;
        end
    end
endmodule

// File: doc/rv32i_imem_fetch.md
RV32I_IMEM_FETCH -- requirements
Module: rv32i_imem_fetch

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, words per line buffer (power of 2, 2..8).
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, the instruction driven while not valid.
REQ-003 SHALL have port clk_i, input, 1, clock; all state updates on the rising edge.
REQ-004 SHALL have port resetn_i, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port cpu_add_i, input, 32, byte fetch address from the datapath PC.
REQ-006 SHALL have port cpu_data_o, output, 32, instruction for cpu_add_i.
REQ-007 SHALL have port cpu_valid_o, output, 1, high when cpu_data_o is the word at cpu_add_i; drives the datapath imem_valid_i.
REQ-008 SHALL have port flush_i, input, 1, invalidate the line buffer.
REQ-009 SHALL have port mem_req_o, output, 1, read request to instruction memory.
REQ-010 SHALL have port mem_add_o, output, 32, word-aligned request address.
REQ-011 SHALL have port mem_gnt_i, input, 1, request accepted this cycle.
REQ-012 SHALL have port mem_rvalid_i, input, 1, read response valid.
REQ-013 SHALL have port mem_rdata_i, input, 32, read response data.
REQ-014 SHALL have port mem_err_i, input, 1, response error, qualified by mem_rvalid_i.
REQ-015 SHALL have port err_o, output, 1, one-cycle pulse on an errored refill.

Function
REQ-016 SHALL hold one line: LINE_WORDS data words, a tag equal to line base address bits [31:log2(LINE_WORDS)+2], and a line_valid bit.
REQ-017 SHALL compute hit combinationally: line_valid, tag equal to cpu_add_i tag, state IDLE, flush_i low.
REQ-018 SHALL drive cpu_valid_o = hit and cpu_data_o = word[cpu_add_i word index] on hit, else NOP_INSTR; cpu_add_i[1:0] ignored.
REQ-019 SHALL implement FSM IDLE, REFILL, DRAIN.
REQ-020 IDLE -> REFILL on a miss with flush_i low: clear line_valid, latch the miss tag, zero issue and receive counters.
REQ-021 In REFILL, SHALL assert mem_req_o while issue count < LINE_WORDS, mem_add_o = line base + 4*issue count; issue count increments on mem_gnt_i.
REQ-022 SHALL hold mem_req_o and mem_add_o stable until granted; mem_req_o SHALL be low in IDLE and DRAIN.
REQ-023 SHALL take responses in order, writing mem_rdata_i into word[receive count] and incrementing receive count on each mem_rvalid_i.
REQ-024 SHALL, on the LINE_WORDS-th error-free response, set line_valid, return to IDLE; first hit possible the following cycle (miss-to-hit = LINE_WORDS grants + memory latency + 1).
REQ-025 SHALL ignore cpu_add_i changes during REFILL; the line completes for the latched tag, then hit/miss is re-evaluated in IDLE.
REQ-026 SHALL, on mem_rvalid_i with mem_err_i, pulse err_o, keep line_valid low, stop issuing, go to DRAIN.
REQ-027 SHALL, on flush_i in REFILL, stop issuing and go to DRAIN; flush_i in IDLE clears line_valid, stays IDLE that cycle.
REQ-028 In DRAIN, SHALL discard responses until receive count equals issue count, then go to IDLE with line_valid low (refetch on next miss evaluation).
REQ-029 SHALL tolerate mem_gnt_i and mem_rvalid_i in the same cycle, both counters updating.
REQ-030 SHALL ignore mem_rvalid_i with no request outstanding.
REQ-031 Counters SHALL be log2(LINE_WORDS)+1 bits wide and never wrap within a refill.

Reset
REQ-032 SHALL, on resetn_i low, asynchronously set FSM IDLE, line_valid 0, counters 0, tag 0, data words 0.
REQ-033 SHALL drive during reset: cpu_valid_o 0, cpu_data_o NOP_INSTR, mem_req_o 0, mem_add_o 0, err_o 0.
REQ-034 SHALL treat reset asserted mid-refill as abandonment; late responses after release are ignored per REQ-030.

Verification
REQ-035 Cold miss: reset release, cpu_add_i=0x0000_0008, gnt always 1, rvalid 1 cycle after gnt -> requests 0x0,0x4,0x8,0xC, then cpu_valid_o=1 with word[2].
REQ-036 Hit sweep: after REQ-035, cpu_add_i 0x0,0x4,0x8,0xC back to back -> cpu_valid_o=1 every cycle, no mem_req_o.
REQ-037 Line cross: cpu_add_i 0x10 after REQ-036 -> cpu_valid_o=0, refill 0x10..0x1C, old line not hit.
REQ-038 Backpressure: mem_gnt_i low 3 cycles on second request -> mem_add_o held at base+4, line still correct.
REQ-039 Error: mem_err_i on response 2 of 4 -> err_o one-cycle pulse, remaining responses drained, cpu_valid_o=0, new refill then starts.
REQ-040 Flush and reset mid-refill: flush_i after 2 grants -> DRAIN, no cpu_valid_o until clean refill; resetn_i low mid-refill -> all outputs at REQ-033 values immediately.
